// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive block and its CPU IO wrapper.
//   Contents:
//     rx_state_t    - receiver FSM state encoding
//     UART_RX_DATA  - IO port number (A[15:8]) of the received-byte register
//     UART_RX_STAT  - IO port number of the status / flag-clear register
//     STAT_*_BIT    - bit positions inside the status byte
//     pack_status() - assembles the status byte from the three flags
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] UART_RX_DATA = 8'h01;
  localparam logic [7:0] UART_RX_STAT = 8'h03;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;
  localparam int STAT_FERR_BIT  = 2;

  // Status byte: unused upper bits read as zero.
  function automatic logic [7:0] pack_status(input logic valid,
                                             input logic ovr,
                                             input logic ferr);
    logic [7:0] s;
    s                 = 8'h00;
    s[STAT_VALID_BIT] = valid;
    s[STAT_OVR_BIT]   = ovr;
    s[STAT_FERR_BIT]  = ferr;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   8N1 serial receiver: input synchronizer, start-bit qualification,
//   mid-bit sampling of eight data bits (LSB first) and stop-bit check.
//   Ports:
//     clk      in   clock, rising edge
//     nRESET   in   asynchronous active-low reset
//     rxd      in   raw asynchronous serial line (idle high)
//     rx_byte  out  assembled byte, valid while done is high
//     done     out  one-cycle pulse: frame ended with a good stop bit
//     ferr     out  one-cycle pulse: frame ended with a bad (low) stop bit
//   Parameters:
//     DIV      clocks per bit
//     HALF     clocks from start edge to start-bit mid-point
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV  = 434,
  parameter int HALF = 217
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       ferr
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_L  = CW'(DIV);
  localparam logic [CW-1:0] HALF_L = CW'(HALF);
  localparam logic [CW-1:0] ONE_L  = CW'(1);

  // Two synchronizer flops plus one history flop for falling-edge detect.
  logic sync1, sync2, sync_prev;

  rx_state_t state, state_next;

  logic [CW-1:0] count;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic fall;
  logic expire;
  logic last_bit;
  logic load_half;
  logic load_div;
  logic shift_en;

  // Flops reset to the idle line level so reset release never looks like
  // a start edge.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fall     = sync_prev & ~sync2;
  // A load of N expires N clocks later: the action fires on the clock
  // edge where the counter steps off 1.
  assign expire   = (count <= ONE_L);
  assign last_bit = (bit_idx == 3'd7);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (fall) state_next = ST_START;
      end
      ST_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (expire) state_next = sync2 ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (expire && last_bit) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (expire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: output / control logic ----------------
  always_comb begin
    load_half = 1'b0;
    load_div  = 1'b0;
    shift_en  = 1'b0;
    done      = 1'b0;
    ferr      = 1'b0;
    case (state)
      ST_IDLE: begin
        load_half = fall;
      end
      ST_START: begin
        load_div = expire & ~sync2;
      end
      ST_DATA: begin
        // Every data sample reloads the bit timer; after the eighth it
        // times the stop bit.
        if (expire) begin
          shift_en = 1'b1;
          load_div = 1'b1;
        end
      end
      ST_STOP: begin
        if (expire) begin
          done = sync2;
          ferr = ~sync2;
        end
      end
      default: begin
        load_half = 1'b0;
      end
    endcase
  end

  // ---------------- bit timer, bit index, shift register ----------------
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      count   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (load_half) begin
        count <= HALF_L;
      end else if (load_div) begin
        count <= DIV_L;
      end else if (count != '0) begin
        count <= count - ONE_L;
      end

      if (load_half) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end

      // LSB arrives first, so bits enter at the top and move down.
      if (shift_en) begin
        shift <= {sync2, shift[7:1]};
      end
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/uart_rx_io.sv
// ---------------------------------------------------------------------------
// uart_rx_io
//   UART receiver with a Z80-style IO interface: one-byte holding register,
//   valid / overrun / framing-error flags and IO port decode.
//   Ports:
//     clk       in     clock, rising edge
//     nRESET    in     asynchronous active-low reset
//     rxd       in     raw serial line, idle high, 8N1
//     Address   in     CPU A[15:8], the IO port number
//     Data      inout  CPU data bus; driven only during a decoded IO read
//     IORQ      in     active-high IO request strobe
//     RD        in     active-high read strobe
//     WR        in     active-high write strobe
//     rx_ready  out    holding register contains an unread byte
//   IO map:
//     read  UART_RX_DATA : holding register; the byte is consumed (valid
//                          cleared) when the read access ends
//     read  UART_RX_STAT : {5'b0, ferr, ovr, valid}
//     write UART_RX_STAT : clears ovr and ferr (data ignored)
// ---------------------------------------------------------------------------
module uart_rx_io
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       rxd,
  input  logic [7:0] Address,
  inout  wire  [7:0] Data,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  output logic       rx_ready
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;

  logic [7:0] core_byte;
  logic       core_done;
  logic       core_ferr;

  logic [7:0] hold;
  logic       valid;
  logic       ovr;
  logic       ferr_flag;

  logic rd_data, rd_stat, wr_stat;
  logic rd_data_prev, wr_stat_prev;
  logic pop, clr;
  logic [7:0] status;

  uart_rx_core #(
    .DIV  (DIV),
    .HALF (HALF)
  ) u_core (
    .clk     (clk),
    .nRESET  (nRESET),
    .rxd     (rxd),
    .rx_byte (core_byte),
    .done    (core_done),
    .ferr    (core_ferr)
  );

  // ---------------- bus decode ----------------
  assign rd_data = IORQ & RD & (Address == UART_RX_DATA);
  assign rd_stat = IORQ & RD & (Address == UART_RX_STAT);
  assign wr_stat = IORQ & WR & (Address == UART_RX_STAT);

  // A read may span several clocks; consuming the byte when the access
  // ends keeps the value stable for the whole access and pops only once.
  assign pop = rd_data_prev & ~rd_data;
  // Flag clear acts on the first clock of a write access only.
  assign clr = wr_stat & ~wr_stat_prev;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rd_data_prev <= 1'b0;
      wr_stat_prev <= 1'b0;
      hold         <= 8'h00;
      valid        <= 1'b0;
      ovr          <= 1'b0;
      ferr_flag    <= 1'b0;
    end else begin
      rd_data_prev <= rd_data;
      wr_stat_prev <= wr_stat;

      // A new byte is accepted if the register is empty or is being
      // emptied this very clock; otherwise the old byte is kept.
      if (core_done && (!valid || pop)) begin
        hold <= core_byte;
      end
      valid <= core_done | (valid & ~pop);

      // A new event in the same clock as a clear is not lost.
      ovr       <= (ovr & ~clr) | (core_done & valid & ~pop);
      ferr_flag <= (ferr_flag & ~clr) | core_ferr;
    end
  end

  assign status   = pack_status(valid, ovr, ferr_flag);
  assign rx_ready = valid;

  assign Data = rd_data ? hold :
                rd_stat ? status :
                8'bzzzz_zzzz;

endmodule

// File: tb/tb_uart_rx_io.sv
module tb_uart_rx_io;
  import uart_pkg::*;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int GAP    = 20;

  logic       clk = 1'b0;
  logic       nRESET;
  logic       rxd;
  logic [7:0] Address;
  logic       IORQ, RD, WR;
  logic       rx_ready;
  wire  [7:0] Data;

  // Undriven bus floats high, so a high-Z bus reads 8'hFF.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup (Data[gi]);
  end

  uart_rx_io #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .rxd      (rxd),
    .Address  (Address),
    .Data     (Data),
    .IORQ     (IORQ),
    .RD       (RD),
    .WR       (WR),
    .rx_ready (rx_ready)
  );

  always #10 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 4128;  // clocks from start edge to rx_ready, measured in test_basic

  // Reference model of the CPU-visible registers.
  logic [7:0] m_hold;
  logic       m_valid, m_ovr, m_ferr;

  function automatic void model_reset();
    m_hold = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic pop_same);
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else if (!m_valid || pop_same) begin
      m_hold  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  function automatic void model_pop();
    m_valid = 1'b0;
  endfunction

  function automatic void model_clear();
    m_ovr = 1'b0; m_ferr = 1'b0;
  endfunction

  function automatic logic [7:0] model_status();
    return 8'(4 * int'(m_ferr) + 2 * int'(m_ovr) + int'(m_valid));
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    $display("frame %02h stop=%0d", b, stop_bit);
    @(negedge clk); rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] d);
    @(negedge clk); Address = addr; IORQ = 1'b1; RD = 1'b1;
    @(negedge clk); d = Data;
    IORQ = 1'b0; RD = 1'b0; Address = 8'h00;
    @(negedge clk);
    $display("read  port %02h -> %02h", addr, d);
  endtask

  task automatic bus_write(input logic [7:0] addr);
    @(negedge clk); Address = addr; IORQ = 1'b1; WR = 1'b1;
    @(negedge clk); IORQ = 1'b0; WR = 1'b0; Address = 8'h00;
    @(negedge clk);
    $display("write port %02h", addr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    nRESET = 1'b0; rxd = 1'b1; Address = 8'h00; IORQ = 1'b0; RD = 1'b0; WR = 1'b0;
    repeat (5) @(negedge clk);
    nRESET = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL reset_rx_ready got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL reset_status got %02h want %02h", d, model_status());
    end
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL reset_data got %02h want %02h", d, m_hold);
    end
    model_pop();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    fork
      send_frame(8'h55, 1'b1);
      begin
        int  k;
        bit  seen;
        @(negedge clk);
        k = 0; seen = 1'b0;
        while (!seen && k < 11 * DIV) begin
          @(negedge clk);
          k++;
          if (rx_ready === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
          miscompares++; $display("FAIL basic_latency rx_ready got 0 want 1 within %0d clocks", 11 * DIV);
        end else begin
          lat = k;
        end
      end
    join
    model_frame(8'h55, 1'b1, 1'b0);
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL basic_rx_ready got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL basic_status got %02h want %02h", d, model_status());
    end
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL basic_data got %02h want %02h", d, m_hold);
    end
    model_pop();
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL basic_rx_ready_after got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL basic_status_after got %02h want %02h", d, model_status());
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1, 1'b0);
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL ovr_status got %02h want %02h", d, model_status());
    end
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL ovr_data got %02h want %02h", d, m_hold);
    end
    model_pop();
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL ovr_status_popped got %02h want %02h", d, model_status());
    end
    bus_write(UART_RX_STAT); model_clear();
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL ovr_status_cleared got %02h want %02h", d, model_status());
    end
  endtask

  task automatic test_framing();
    logic [7:0] d;
    send_frame(8'hFF, 1'b0); model_frame(8'hFF, 1'b0, 1'b0);
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL ferr_rx_ready got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL ferr_status got %02h want %02h", d, model_status());
    end
    bus_write(UART_RX_STAT); model_clear();
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL ferr_status_cleared got %02h want %02h", d, model_status());
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    @(negedge clk); rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (DIV) @(negedge clk);
    $display("glitch 100 clocks");
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL glitch_rx_ready got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL glitch_status got %02h want %02h", d, model_status());
    end
    send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1, 1'b0);
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL glitch_data got %02h want %02h", d, m_hold);
    end
    model_pop();
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL glitch_status_after got %02h want %02h", d, model_status());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic [7:0] part;
    part = 8'h5A;
    send_frame(8'h12, 1'b1); model_frame(8'h12, 1'b1, 1'b0);
    // Start bit plus data bits 0..3, then reset.
    @(negedge clk); rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      repeat (DIV) @(negedge clk);
    end
    nRESET = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    model_reset();
    $display("reset mid-frame");
    repeat (DIV) @(negedge clk);
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL midrst_rx_ready got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL midrst_status got %02h want %02h", d, model_status());
    end
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL midrst_hold got %02h want %02h", d, m_hold);
    end
    model_pop();
    send_frame(8'h81, 1'b1); model_frame(8'h81, 1'b1, 1'b0);
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL midrst_data got %02h want %02h", d, m_hold);
    end
    model_pop();
  endtask

  task automatic test_hold_read();
    logic [7:0] d, d_during, y;
    y = 8'($urandom_range(0, 254));
    if (y == 8'h77) y = 8'h78;
    send_frame(8'h77, 1'b1); model_frame(8'h77, 1'b1, 1'b0);
    // Read held from before the start edge and released so that the pop
    // lands on the clock where the new byte completes.
    @(negedge clk); Address = UART_RX_DATA; IORQ = 1'b1; RD = 1'b1;
    d_during = 8'h00;
    fork
      send_frame(y, 1'b1);
      begin
        @(negedge clk);
        repeat (lat - 2) @(negedge clk);
        d_during = Data;
        IORQ = 1'b0; RD = 1'b0; Address = 8'h00;
      end
    join
    $display("held read -> %02h", d_during);
    vectors++;
    if (d_during !== m_hold) begin
      miscompares++; $display("FAIL hold_old_byte got %02h want %02h", d_during, m_hold);
    end
    model_frame(y, 1'b1, 1'b1);
    vectors++;
    if (rx_ready !== m_valid) begin
      miscompares++; $display("FAIL hold_rx_ready got %b want %b", rx_ready, m_valid);
    end
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL hold_status got %02h want %02h", d, model_status());
    end
    bus_read(8'h02, d);
    vectors++;
    if (d !== 8'hFF) begin
      miscompares++; $display("FAIL port02_highz got %02h want FF (bus released)", d);
    end
    bus_read(UART_RX_DATA, d);
    vectors++;
    if (d !== m_hold) begin
      miscompares++; $display("FAIL hold_new_byte got %02h want %02h", d, m_hold);
    end
    model_pop();
    bus_read(UART_RX_STAT, d);
    vectors++;
    if (d !== model_status()) begin
      miscompares++; $display("FAIL hold_status_after got %02h want %02h", d, model_status());
    end
  endtask

  task automatic test_random();
    logic [7:0] d, b;
    logic       ok;
    int         op;
    for (int n = 0; n < 5; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok); model_frame(b, ok, 1'b0);
      vectors++;
      if (rx_ready !== m_valid) begin
        miscompares++; $display("FAIL rand%0d_rx_ready got %b want %b", n, rx_ready, m_valid);
      end
      bus_read(UART_RX_STAT, d);
      vectors++;
      if (d !== model_status()) begin
        miscompares++; $display("FAIL rand%0d_status got %02h want %02h", n, d, model_status());
      end
      op = $urandom_range(0, 2);
      if (op == 0) begin
        bus_read(UART_RX_DATA, d);
        vectors++;
        if (d !== m_hold) begin
          miscompares++; $display("FAIL rand%0d_data got %02h want %02h", n, d, m_hold);
        end
        model_pop();
      end else if (op == 1) begin
        bus_write(UART_RX_STAT); model_clear();
      end
      bus_read(UART_RX_STAT, d);
      vectors++;
      if (d !== model_status()) begin
        miscompares++; $display("FAIL rand%0d_status_after got %02h want %02h", n, d, model_status());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_midframe();
    test_hold_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_io.md
UART_RX_IO -- requirements
Module: uart_rx_io

Interface
REQ-001 Parameter CLK_HZ, default 50000000, frequency of clk in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD (integer, truncated), HALF = DIV/2.
REQ-003 clk  input  1  single clock, rising edge; all state in this domain.
REQ-004 nRESET  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Address  input  8  CPU address bits A[15:8] for IO decode.
REQ-007 Data  inout  8  CPU data bus; driven only during a decoded IO read, else high-Z.
REQ-008 IORQ, RD, WR  input  1 each  active-high CPU bus strobes; the top level inverts the Z80 n-strobes.
REQ-009 rx_ready  output  1  level, equals the holding-register valid flag.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-011 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE: a synchronized high-to-low transition SHALL load the bit counter with HALF and enter START.
REQ-013 START: at counter expiry, sampled 0 -> reload DIV, enter DATA; sampled 1 -> glitch, return to IDLE with no flag change.
REQ-014 DATA: sample one bit per DIV clocks into the shift register LSB first; after the 8th sample, reload DIV and enter STOP.
REQ-015 STOP: sample at expiry; 1 -> byte complete; 0 -> set ferr, discard byte; both return to IDLE in the same cycle.
REQ-016 Byte complete with valid=0 SHALL load the holding register and set valid on the next clock.
REQ-017 Byte complete with valid=1 and no pop in the same cycle SHALL set ovr, discard the new byte and keep the old byte.
REQ-018 Byte complete in the same cycle as a pop SHALL load the new byte with valid remaining 1 and ovr unchanged.
REQ-019 IO read port 0x01 (IORQ&RD&Address==8'h01) SHALL drive the holding register onto Data combinationally.
REQ-020 IO read port 0x03 SHALL drive status {5'b0, ferr, ovr, valid} onto Data.
REQ-021 Pop SHALL occur exactly once per read access: on the first clock where the port-0x01 read term deasserts after being asserted; a pop clears valid.
REQ-022 IO write to port 0x03 (IORQ&WR&Address==8'h03) SHALL clear ovr and ferr, once per access; the data value is ignored.
REQ-023 All other addresses and strobe combinations SHALL leave Data high-Z and state unchanged.
REQ-024 Reception SHALL continue independently of bus activity; a pop never aborts a frame in progress.

Reset
REQ-025 nRESET low SHALL asynchronously set FSM=IDLE, counters=0, shift and holding registers=8'h00, valid=ovr=ferr=0, rx_ready=0, both synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release the receiver waits for a new start edge.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum, port constants UART_RX_DATA=8'h01 and UART_RX_STAT=8'h03, and the status bit positions.
REQ-028 One sub-module uart_rx_core SHALL contain the synchronizer, FSM and shift register and output a byte plus one-cycle done/ferr pulses; uart_rx_io holds the holding register, flags and bus decode.

Verification (CLK_HZ=50000000, BAUD=115200, DIV=434)
REQ-029 Send 0x55 with good stop -> status read 8'h01, data read 8'h55, next status read 8'h00, rx_ready 1->0 after the read ends.
REQ-030 Send 0xA5 then 0x3C with no read -> status 8'h03, data 8'hA5; write port 0x03 -> status 8'h00.
REQ-031 Send 0xFF with stop bit 0 -> status 8'h04, rx_ready 0; write port 0x03 -> status 8'h00.
REQ-032 Pulse rxd low for 100 clocks -> FSM returns to IDLE, status stays 8'h00; a following 0x3C frame is received correctly.
REQ-033 Assert nRESET after data bit 3 of a frame -> all flags 0; then send 0x81 -> data read 8'h81.
REQ-034 Hold a port-0x01 read across a byte completion -> exactly one pop; the new byte is in the holding register with valid=1 and ovr=0. IO read at port 0x02 -> Data high-Z.
